// File: rtl/game_pkg.sv
// Shared encodings and BCD helpers for the guess-the-number game controller.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Two-digit BCD increment, 99 wraps to 00; result is {tens, ones}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] d1, input logic [3:0] d0);
        logic [3:0] t;
        if (d0 != BCD_MAX)
            return {d1, d0 + 4'd1};
        t = (d1 == BCD_MAX) ? 4'd0 : d1 + 4'd1;
        return {t, 4'd0};
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter 00..99 with synchronous clear (priority) and enable.
module bcd_counter2
    import game_pkg::*;
(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (clr) begin
            d1 <= 4'd0;
            d0 <= 4'd0;
        end else if (en) begin
            {d1, d0} <= bcd_inc(d1, d0);
        end
    end

endmodule

// File: rtl/game_controller.sv
// Guess-the-number sequencer: secret draw, guess counting, LO/HI hint timing, win/loss.
module game_controller
    import game_pkg::*;
#(
    parameter int HINT_CYCLES = 50000000,
    parameter int MAX_GUESSES = 10
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       start,
    input  logic       guess_valid,
    input  logic [3:0] g1,
    input  logic [3:0] g0,
    output logic [2:0] state,
    output logic [3:0] rdm1,
    output logic [3:0] rdm0,
    output logic [3:0] count1,
    output logic [3:0] count0,
    output logic       neg
);

    localparam int TW = (HINT_CYCLES > 1) ? $clog2(HINT_CYCLES) : 1;
    localparam logic [TW-1:0] HINT_LOAD = TW'(HINT_CYCLES - 1);
    localparam logic [7:0] MAX_BCD = {4'(MAX_GUESSES / 10), 4'(MAX_GUESSES % 10)};

    state_t        state_q, state_d;
    logic [3:0]    rdm1_q, rdm1_d, rdm0_q, rdm0_d;
    logic          neg_q, neg_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    free1, free0;
    logic          in_game, digits_ok, acc;
    logic          g_eq, g_lt;
    logic [7:0]    cnt_n;

    bcd_counter2 u_free (
        .Clock (Clock),
        .Resetn(Resetn),
        .clr   (1'b0),
        .en    (1'b1),
        .d1    (free1),
        .d0    (free0)
    );

    bcd_counter2 u_guesses (
        .Clock (Clock),
        .Resetn(Resetn),
        .clr   (start),
        .en    (acc),
        .d1    (count1),
        .d0    (count0)
    );

    assign in_game   = (state_q == S_PLAY) || (state_q == S_LO) || (state_q == S_HI);
    assign digits_ok = (g1 <= BCD_MAX) && (g0 <= BCD_MAX);
    assign acc       = guess_valid && !start && in_game && digits_ok;

    // Digit-wise compare is equivalent to numeric compare for valid BCD.
    assign g_eq  = (g1 == rdm1_q) && (g0 == rdm0_q);
    assign g_lt  = (g1 < rdm1_q) || ((g1 == rdm1_q) && (g0 < rdm0_q));
    assign cnt_n = bcd_inc(count1, count0);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            rdm1_q  <= 4'd0;
            rdm0_q  <= 4'd0;
            neg_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            rdm1_q  <= rdm1_d;
            rdm0_q  <= rdm0_d;
            neg_q   <= neg_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdm1_d  = rdm1_q;
        rdm0_d  = rdm0_q;
        neg_d   = neg_q;
        timer_d = timer_q;
        if (start) begin
            state_d = S_PLAY;
            rdm1_d  = free1;
            rdm0_d  = free0;
            neg_d   = 1'b0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: ;
                S_PLAY, S_LO, S_HI: begin
                    if (acc) begin
                        if (g_eq) begin
                            state_d = S_DONE;
                            neg_d   = 1'b0;
                        end else if (cnt_n == MAX_BCD) begin
                            state_d = S_DONE;
                            neg_d   = 1'b1;
                        end else begin
                            state_d = g_lt ? S_LO : S_HI;
                            timer_d = HINT_LOAD;
                        end
                    end else if (state_q != S_PLAY) begin
                        // Hint expires one edge after the timer reaches zero.
                        if (timer_q == '0)
                            state_d = S_PLAY;
                        else
                            timer_d = timer_q - TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign state = state_q;
    assign rdm1  = rdm1_q;
    assign rdm0  = rdm0_q;
    assign neg   = neg_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed + randomized bench for game_controller against an integer-level game model.
module tb_game_controller;

    localparam int HOLD = 4;
    localparam int MAXG = 3;

    logic       Clock, Resetn, start, guess_valid;
    logic [3:0] g1, g0;
    logic [2:0] state;
    logic [3:0] rdm1, rdm0, count1, count0;
    logic       neg;

    int total = 0;
    int bad   = 0;

    // Reference model: whole-number game state
    int mfree, msec, mcnt, mst, mtmr;
    bit mneg;

    game_controller #(.HINT_CYCLES(HOLD), .MAX_GUESSES(MAXG)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .start      (start),
        .guess_valid(guess_valid),
        .g1         (g1),
        .g0         (g0),
        .state      (state),
        .rdm1       (rdm1),
        .rdm0       (rdm0),
        .count1     (count1),
        .count0     (count0),
        .neg        (neg)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"},  32'(state),  32'(mst));
        chk({tag, ".rdm1"},   32'(rdm1),   32'(msec / 10));
        chk({tag, ".rdm0"},   32'(rdm0),   32'(msec % 10));
        chk({tag, ".count1"}, 32'(count1), 32'(mcnt / 10));
        chk({tag, ".count0"}, 32'(count0), 32'(mcnt % 10));
        chk({tag, ".neg"},    32'(neg),    32'(mneg));
    endtask

    task automatic model_reset();
        mfree = 0; msec = 0; mcnt = 0; mst = 0; mtmr = 0; mneg = 0;
    endtask

    // Entered just after a negedge; drives inputs, steps model at posedge, checks, returns at negedge.
    task automatic tick(input bit s, input bit v, input logic [3:0] a, input logic [3:0] b,
                        input string tag);
        int gv;
        bit ok;
        start = s; guess_valid = v; g1 = a; g0 = b;
        @(posedge Clock);
        ok = v && !s && (mst >= 1 && mst <= 3) && (a <= 9) && (b <= 9);
        gv = int'(a) * 10 + int'(b);
        if (s) begin
            msec = mfree; mcnt = 0; mneg = 0; mtmr = 0; mst = 1;
        end else if (ok) begin
            mcnt++;
            if (gv == msec) begin
                mst = 4; mneg = 0;
            end else if (mcnt == MAXG) begin
                mst = 4; mneg = 1;
            end else begin
                mst = (gv < msec) ? 2 : 3;
                mtmr = HOLD - 1;
            end
        end else if (mst == 2 || mst == 3) begin
            if (mtmr == 0) mst = 1;
            else mtmr--;
        end
        mfree = (mfree + 1) % 100;
        #1;
        chk_model(tag);
        @(negedge Clock);
        start = 0; guess_valid = 0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(0, 0, 4'd0, 4'd0, tag);
    endtask

    task automatic start_at(input int sec);
        for (int i = 0; i < 100 && mfree != sec; i++) tick(0, 0, 4'd0, 4'd0, "wait");
        tick(1, 0, 4'd0, 4'd0, "start");
        chk("start_at.state", 32'(state), 32'd1);
        chk("start_at.rdm", {24'd0, rdm1, rdm0}, 32'(((sec / 10) << 4) | (sec % 10)));
    endtask

    initial begin
        start = 0; guess_valid = 0; g1 = 0; g0 = 0;
        Resetn = 1'b0;
        model_reset();
        @(negedge Clock);
        chk_model("reset");
        @(negedge Clock);
        Resetn = 1'b1;

        // Idle with ignored guesses, free counter wraps twice, start on the 238th edge
        for (int i = 0; i < 237; i++)
            tick(0, (i % 7) == 0, 4'(i % 10), 4'(i % 9), "idle");
        chk("idle.state", 32'(state), 32'd0);
        tick(1, 0, 4'd0, 4'd0, "start237");
        chk("s237.rdm1", 32'(rdm1), 32'd3);
        chk("s237.rdm0", 32'(rdm0), 32'd7);
        chk("s237.state", 32'(state), 32'd1);

        // Secret 37: LO, hint expiry, HI, then win during HI
        tick(0, 1, 4'd2, 4'd5, "g25");
        chk("g25.state", 32'(state), 32'd2);
        chk("g25.count", {24'd0, count1, count0}, 32'h01);
        idle(3, "lo_hold");
        chk("lo_hold.state", 32'(state), 32'd2);
        tick(0, 0, 4'd0, 4'd0, "lo_exp");
        chk("lo_exp.state", 32'(state), 32'd1);
        tick(0, 1, 4'd5, 4'd2, "g52");
        chk("g52.state", 32'(state), 32'd3);
        tick(0, 1, 4'd3, 4'd7, "g37");
        chk("g37.state", 32'(state), 32'd4);
        chk("g37.neg", 32'(neg), 32'd0);
        chk("g37.count", {24'd0, count1, count0}, 32'h03);
        for (int i = 0; i < 6; i++) tick(0, 1, 4'(i), 4'd1, "done_hold");
        chk("done_hold.state", 32'(state), 32'd4);

        // Loss at the guess limit, then guesses in DONE are ignored
        start_at(37);
        tick(0, 1, 4'd1, 4'd0, "g10");
        tick(0, 1, 4'd9, 4'd0, "g90");
        tick(0, 1, 4'd5, 4'd0, "g50");
        chk("loss.state", 32'(state), 32'd4);
        chk("loss.neg", 32'(neg), 32'd1);
        chk("loss.count", {24'd0, count1, count0}, 32'h03);
        tick(0, 1, 4'd3, 4'd7, "loss_hold");
        chk("loss_hold.neg", 32'(neg), 32'd1);

        // Non-BCD digits are not guesses
        start_at(37);
        tick(0, 1, 4'hA, 4'd1, "badg1");
        tick(0, 1, 4'd2, 4'hC, "badg0");
        chk("bad.count", {24'd0, count1, count0}, 32'h00);
        chk("bad.state", 32'(state), 32'd1);

        // start beats a simultaneous guess during LO
        tick(0, 1, 4'd0, 4'd5, "g05");
        chk("g05.state", 32'(state), 32'd2);
        tick(1, 1, 4'd3, 4'd7, "start_vs_guess");
        chk("svg.state", 32'(state), 32'd1);
        chk("svg.count", {24'd0, count1, count0}, 32'h00);

        // Randomized play
        for (int i = 0; i < 1500; i++)
            tick(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)), "rnd");

        // Async reset in the middle of a HI hint
        start_at(37);
        tick(0, 1, 4'd5, 4'd2, "pre_rst");
        chk("pre_rst.state", 32'(state), 32'd3);
        #2 Resetn = 1'b0;
        #1;
        model_reset();
        chk_model("async_rst");
        @(negedge Clock);
        Resetn = 1'b1;
        idle(5, "post_rst");
        chk("post_rst.state", 32'(state), 32'd0);
        start_at(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
